nic_counter_bank: RTL

Parametrised statistics counter bank for the NIC. It replaces fixed five-counter blocks with NUM_CNT generic counters, each incremented by a variable amount (packets or bytes). It supports clear-on-read, global clear and sticky per-counter overflow flags. It sits in the single NIC core clock domain; callers synchronise event strobes into clk before this block, and CDC is out of scope.

---
 rtl/nic_counter_pkg.sv | 29 ++
 rtl/nic_counter_cell.sv | 59 +++++
 rtl/nic_counter_bank.sv | 104 ++++++++++
 3 files changed

// File: rtl/nic_counter_pkg.sv
// Shared constants, NIC counter index names and read-response type for nic_counter_bank.
// Build option NIC_COUNTERS_SATURATE_EN is consumed by nic_counter_cell.
package nic_counter_pkg;

   localparam int NIC_NUM_CNT_DEF   = 8;
   localparam int NIC_CNT_WIDTH_DEF = 64;
   localparam int NIC_INC_WIDTH_DEF = 16;
   localparam int NIC_ID_WIDTH_DEF  = 8;
   localparam int NIC_CNT_WIDTH_MAX = 64;

   typedef enum logic [7:0] {
      CNT_RPC_IN   = 8'd0,
      CNT_RPC_OUT  = 8'd1,
      CNT_PKT_OUT  = 8'd2,
      CNT_PKT_IN   = 8'd3,
      CNT_PDROP_TX = 8'd4,
      CNT_PDROP_RX = 8'd5,
      CNT_BYTE_OUT = 8'd6,
      CNT_BYTE_IN  = 8'd7
   } nic_cnt_id_e;

   // data is sized for the widest counter; narrower banks zero-extend into it
   typedef struct packed {
      logic [NIC_CNT_WIDTH_MAX-1:0] data;
      logic                         ovf;
      logic                         err;
   } nic_rd_rsp_t;

endpackage

// File: rtl/nic_counter_cell.sv
// One statistics counter with sticky overflow flag: add, global clear, clear-on-read reload.
// Defining NIC_COUNTERS_SATURATE_EN makes the counter stick at all-ones instead of wrapping.
module nic_counter_cell
   import nic_counter_pkg::*;
#(
   parameter int CNT_WIDTH = NIC_CNT_WIDTH_DEF,
   parameter int INC_WIDTH = NIC_INC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc_valid,
   input  logic [INC_WIDTH-1:0] inc_amount,
   input  logic                 clr_all,
   input  logic                 rd_clear,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 ovf
);

   logic [CNT_WIDTH-1:0] inc_ext_s;
   logic [CNT_WIDTH:0]   sum_s;
   logic [CNT_WIDTH-1:0] add_res_s;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic                 ovf_r;

   // widen the increment and form the carry-extended sum
   always_comb begin
      inc_ext_s = CNT_WIDTH'(inc_amount);
      sum_s     = {1'b0, cnt_r} + {1'b0, inc_ext_s};
`ifdef NIC_COUNTERS_SATURATE_EN
      add_res_s = sum_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum_s[CNT_WIDTH-1:0];
`else
      add_res_s = sum_s[CNT_WIDTH-1:0];
`endif
   end

   // counter and sticky flag; a clear-on-read reloads the pending increment so it is not lost
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= {CNT_WIDTH{1'b0}};
         ovf_r <= 1'b0;
      end else if (clr_all) begin
         cnt_r <= {CNT_WIDTH{1'b0}};
         ovf_r <= 1'b0;
      end else if (rd_clear) begin
         cnt_r <= inc_valid ? inc_ext_s : {CNT_WIDTH{1'b0}};
         ovf_r <= 1'b0;
      end else if (inc_valid) begin
         cnt_r <= add_res_s;
         ovf_r <= ovf_r | sum_s[CNT_WIDTH];
      end else begin
         cnt_r <= cnt_r;
         ovf_r <= ovf_r;
      end
   end

   assign cnt = cnt_r;
   assign ovf = ovf_r;

endmodule

// File: rtl/nic_counter_bank.sv
// NUM_CNT statistics counters with registered increment stage, read mux and response register.
// Counter wrap vs. saturate is selected by NIC_COUNTERS_SATURATE_EN (see nic_counter_cell).
module nic_counter_bank
   import nic_counter_pkg::*;
#(
   parameter int NUM_CNT   = NIC_NUM_CNT_DEF,
   parameter int CNT_WIDTH = NIC_CNT_WIDTH_DEF,
   parameter int INC_WIDTH = NIC_INC_WIDTH_DEF,
   parameter int ID_WIDTH  = NIC_ID_WIDTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CNT-1:0]           inc_valid,
   input  logic [NUM_CNT*INC_WIDTH-1:0] inc_amount,
   input  logic                         clr_all,
   input  logic                         rd_req,
   input  logic [ID_WIDTH-1:0]          rd_id,
   input  logic                         rd_clear,
   output logic                         rd_valid,
   output logic [CNT_WIDTH-1:0]         rd_data,
   output logic                         rd_ovf,
   output logic                         rd_err
);

   localparam logic [ID_WIDTH:0] NUM_CNT_ID = (ID_WIDTH+1)'(NUM_CNT);

   logic [NUM_CNT-1:0]           inc_valid_r;
   logic [NUM_CNT*INC_WIDTH-1:0] inc_amount_r;
   logic [CNT_WIDTH-1:0]         cnt_s [NUM_CNT];
   logic [NUM_CNT-1:0]           ovf_s;
   logic [NUM_CNT-1:0]           rd_sel_s;
   logic [NUM_CNT-1:0]           rd_clr_hit_s;
   logic                         rd_in_range_s;
   logic [CNT_WIDTH-1:0]         sel_data_s;
   logic                         sel_ovf_s;
   nic_rd_rsp_t                  rsp_s;
   nic_rd_rsp_t                  rsp_r;
   logic                         rd_valid_r;
   logic                         unused_rsp_s;

   // input stage: events are registered once before reaching the counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_valid_r  <= {NUM_CNT{1'b0}};
         inc_amount_r <= {(NUM_CNT*INC_WIDTH){1'b0}};
      end else begin
         inc_valid_r  <= inc_valid;
         inc_amount_r <= inc_amount;
      end
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
      nic_counter_cell #(
         .CNT_WIDTH (CNT_WIDTH),
         .INC_WIDTH (INC_WIDTH)
      ) u_cell (
         .clk        (clk),
         .reset      (reset),
         .inc_valid  (inc_valid_r[g]),
         .inc_amount (inc_amount_r[g*INC_WIDTH +: INC_WIDTH]),
         .clr_all    (clr_all),
         .rd_clear   (rd_clr_hit_s[g]),
         .cnt        (cnt_s[g]),
         .ovf        (ovf_s[g])
      );
   end

   // one-hot read select; out-of-range ids select nothing so they read as zero and clear nothing
   always_comb begin
      rd_in_range_s = ({1'b0, rd_id} < NUM_CNT_ID);
      sel_data_s    = {CNT_WIDTH{1'b0}};
      sel_ovf_s     = 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
         rd_sel_s[i]     = rd_in_range_s & (rd_id == ID_WIDTH'(i));
         rd_clr_hit_s[i] = rd_sel_s[i] & rd_req & rd_clear;
         sel_data_s      = sel_data_s | (cnt_s[i] & {CNT_WIDTH{rd_sel_s[i]}});
         sel_ovf_s       = sel_ovf_s | (ovf_s[i] & rd_sel_s[i]);
      end
      rsp_s.data = NIC_CNT_WIDTH_MAX'(sel_data_s);
      rsp_s.ovf  = sel_ovf_s;
      rsp_s.err  = ~rd_in_range_s;
   end

   // response register: one-cycle valid pulse, payload held between reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid_r <= 1'b0;
         rsp_r      <= {$bits(nic_rd_rsp_t){1'b0}};
      end else if (rd_req) begin
         rd_valid_r <= 1'b1;
         rsp_r      <= rsp_s;
      end else begin
         rd_valid_r <= 1'b0;
         rsp_r      <= rsp_r;
      end
   end

   assign rd_valid     = rd_valid_r;
   assign rd_data      = rsp_r.data[CNT_WIDTH-1:0];
   assign rd_ovf       = rsp_r.ovf;
   assign rd_err       = rsp_r.err;
   assign unused_rsp_s = ^rsp_r.data;

endmodule
